// File: rtl/slon_pkg.sv
// -----------------------------------------------------------------------------
// slon_pkg
// Definitions shared by the slon link blocks.
//   SLON_DOUT_WIDTH : default link data width, common to transmitter and receiver
//   RxState_t       : receiver word-alignment state (HUNT, ACQ, LOCKED)
//   Data_t          : one link data word at the default width
// -----------------------------------------------------------------------------
package slon_pkg;

   localparam int SLON_DOUT_WIDTH = 8;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } RxState_t;

   typedef logic [SLON_DOUT_WIDTH-1:0] Data_t;

endpackage

// File: rtl/slon_sync.sv
// -----------------------------------------------------------------------------
// slon_sync
// STAGES-deep flop chain that brings a WIDTH-bit asynchronous bus into clk.
// All bits travel through the same number of flops, so a link clock and its
// data that share one instance keep their relative timing.
//   clk : destination clock
//   rst : synchronous active-high reset, clears the chain
//   d   : asynchronous input bus
//   q   : synchronized bus, STAGES clk cycles behind d
// -----------------------------------------------------------------------------
module slon_sync
   import slon_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain_r [STAGES];

   // Shift the asynchronous bus down the synchronizer chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_r[i] <= '0;
         end
      end else begin
         chain_r[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain_r[i] <= chain_r[i-1];
         end
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/slon_rx.sv
// -----------------------------------------------------------------------------
// slon_rx
// Receive end of the slon source-synchronous link. Oversamples the link clock
// and data in clk, captures one word per in_clk falling edge, checks that the
// word stream increments (mod 2^DOUT_WIDTH), and watches for loss of in_clk.
//   clk        : system clock, at least 4x the in_clk frequency
//   rst        : synchronous active-high reset
//   in_clk     : link clock, asynchronous to clk
//   din        : link data, changes on in_clk rising edge
//   err_clr    : one-cycle pulse clearing err_cnt
//   dout       : last captured word
//   dout_valid : one-cycle strobe when dout updates
//   locked     : receiver is aligned to the incrementing stream
//   clk_lost   : no in_clk falling edge for TIMEOUT cycles
//   err_cnt    : saturating count of mismatches seen while locked
// -----------------------------------------------------------------------------
module slon_rx
   import slon_pkg::*;
#(
   parameter int DOUT_WIDTH    = SLON_DOUT_WIDTH,
   parameter int SYNC_STAGES   = 2,
   parameter int LOCK_COUNT    = 4,
   parameter int UNLOCK_COUNT  = 3,
   parameter int TIMEOUT       = 64,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_clk,
   input  logic [DOUT_WIDTH-1:0]    din,
   input  logic                     err_clr,
   output logic [DOUT_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   output logic                     locked,
   output logic                     clk_lost,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [MW-1:0]            MATCH_ONE   = MW'(1);
   localparam logic [MW-1:0]            LOCK_LAST   = MW'(LOCK_COUNT);
   localparam logic [BW-1:0]            BAD_ONE     = BW'(1);
   localparam logic [BW-1:0]            UNLOCK_LAST = BW'(UNLOCK_COUNT);
   localparam logic [TW-1:0]            TO_LAST     = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]            TO_ONE      = TW'(1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX     = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE     = ERR_CNT_WIDTH'(1);
   localparam logic [DOUT_WIDTH-1:0]    WORD_ONE    = DOUT_WIDTH'(1);

   logic [DOUT_WIDTH:0]     sync_q_s;
   logic                    in_clk_sync_s;
   logic [DOUT_WIDTH-1:0]   data_sync_s;
   logic                    in_clk_hist_r;
   logic                    fall_s;
   logic                    cap_r;
   logic [DOUT_WIDTH-1:0]   word_r;
   logic [TW-1:0]           to_cnt_r;
   logic                    timeout_hit_s;
   RxState_t                state_r;
   logic [DOUT_WIDTH-1:0]   expected_r;
   logic [MW-1:0]           match_cnt_r;
   logic [BW-1:0]           bad_cnt_r;
   logic                    word_match_s;
   logic [ERR_CNT_WIDTH-1:0] err_base_s;
   logic [ERR_CNT_WIDTH-1:0] err_inc_s;

   // Clock and data share one chain so a captured word is exactly the din
   // sample taken alongside the first low in_clk sample.
   slon_sync #(
      .WIDTH  (DOUT_WIDTH + 1),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({in_clk, din}),
      .q   (sync_q_s)
   );

   assign in_clk_sync_s = sync_q_s[DOUT_WIDTH];
   assign data_sync_s   = sync_q_s[DOUT_WIDTH-1:0];
   assign fall_s        = in_clk_hist_r & ~in_clk_sync_s;
   // A detected edge restarts the watchdog, so it cannot fire on that cycle.
   assign timeout_hit_s = (to_cnt_r == TO_LAST) & ~fall_s;
   assign word_match_s  = (word_r == expected_r);

   // Error counter next value: a clear this cycle is applied before counting.
   always_comb begin
      err_base_s = err_cnt;
      err_inc_s  = err_cnt;
      if (err_clr) begin
         err_base_s = '0;
      end else begin
         err_base_s = err_cnt;
      end
      if (err_base_s == ERR_MAX) begin
         err_inc_s = err_base_s;
      end else begin
         err_inc_s = err_base_s + ERR_ONE;
      end
   end

   // Edge detect, word capture stage and link-clock watchdog counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_clk_hist_r <= 1'b0;
         cap_r         <= 1'b0;
         word_r        <= '0;
         to_cnt_r      <= '0;
      end else begin
         in_clk_hist_r <= in_clk_sync_s;
         cap_r         <= fall_s;
         if (fall_s) begin
            word_r   <= data_sync_s;
            to_cnt_r <= '0;
         end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
         end else begin
            to_cnt_r <= to_cnt_r;
         end
      end
   end

   // Alignment FSM with registered outputs; advances only on a captured word,
   // except for the watchdog which forces it back to HUNT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= HUNT;
         expected_r  <= '0;
         match_cnt_r <= '0;
         bad_cnt_r   <= '0;
         err_cnt     <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         locked      <= 1'b0;
         clk_lost    <= 1'b1;
      end else begin
         dout_valid <= cap_r;
         locked     <= (state_r == LOCKED);
         err_cnt    <= err_base_s;
         if (cap_r) begin
            dout       <= word_r;
            clk_lost   <= 1'b0;
            expected_r <= word_r + WORD_ONE;
            case (state_r)
               HUNT: begin
                  match_cnt_r <= MATCH_ONE;
                  if (LOCK_COUNT == 1) begin
                     state_r   <= LOCKED;
                     bad_cnt_r <= '0;
                  end else begin
                     state_r <= ACQ;
                  end
               end
               ACQ: begin
                  if (word_match_s) begin
                     match_cnt_r <= match_cnt_r + MATCH_ONE;
                     if (match_cnt_r + MATCH_ONE == LOCK_LAST) begin
                        state_r   <= LOCKED;
                        bad_cnt_r <= '0;
                     end else begin
                        state_r <= ACQ;
                     end
                  end else begin
                     // The mismatching word itself starts a new run.
                     match_cnt_r <= MATCH_ONE;
                  end
               end
               LOCKED: begin
                  if (word_match_s) begin
                     bad_cnt_r <= '0;
                  end else begin
                     err_cnt <= err_inc_s;
                     if (bad_cnt_r + BAD_ONE == UNLOCK_LAST) begin
                        state_r     <= ACQ;
                        match_cnt_r <= MATCH_ONE;
                        bad_cnt_r   <= '0;
                     end else begin
                        bad_cnt_r <= bad_cnt_r + BAD_ONE;
                     end
                  end
               end
               default: begin
                  state_r     <= HUNT;
                  match_cnt_r <= '0;
                  bad_cnt_r   <= '0;
               end
            endcase
         end else if (timeout_hit_s) begin
            clk_lost <= 1'b1;
            state_r  <= HUNT;
            locked   <= 1'b0;
         end else begin
            clk_lost <= clk_lost;
         end
      end
   end

endmodule

// File: tb/tb_slon_rx.sv
// -----------------------------------------------------------------------------
// tb_slon_rx
// Directed bench for slon_rx. Each transmitted word pushes its expected
// capture (value, locked, err_cnt, edge cycle) into a queue; a monitor pops
// and compares on every dout_valid.
// -----------------------------------------------------------------------------
module tb_slon_rx;
   import slon_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_clk = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        err_clr = 1'b0;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        locked;
   logic        clk_lost;
   logic [15:0] err_cnt;

   typedef struct {
      Data_t w;
      bit    lk;
      int    err;
      int    fc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   slon_rx dut (
      .clk        (clk),
      .rst        (rst),
      .in_clk     (in_clk),
      .din        (din),
      .err_clr    (err_clr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .locked     (locked),
      .clk_lost   (clk_lost),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One link word: rise with new data, fall 4 clk later, period 8 clk.
   // clr raises err_clr on the clk edge that produces this word's dout_valid.
   task automatic send_word(input logic [7:0] w, input bit lk, input int err, input bit clr);
      exp_t e;
      @(negedge clk);
      err_clr = 1'b0;
      in_clk  = 1'b1;
      din     = w;
      repeat (4) @(negedge clk);
      in_clk = 1'b0;
      e.w  = w;
      e.lk = lk;
      e.err = err;
      e.fc = cyc + 1;
      sb_q.push_back(e);
      repeat (3) @(negedge clk);
      err_clr = clr;
   endtask

   // Monitor: every dout_valid must match the oldest outstanding word.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && dout_valid) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_valid: got dout=%0h expected no capture", dout);
         end else begin
            e = sb_q.pop_front();
            check("dout", {24'd0, dout}, {24'd0, e.w});
            check("locked", {31'd0, locked}, {31'd0, e.lk});
            check("err_cnt", {16'd0, err_cnt}, e.err);
            check("clk_lost", {31'd0, clk_lost}, 32'd0);
            check("latency", cyc - e.fc, 32'd3);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_valid", {31'd0, dout_valid}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_clk_lost", {31'd0, clk_lost}, 32'd1);
      check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Acquire from 0x00: locked seen from the 5th word on
      send_word(8'h00, 1'b0, 0, 1'b0);
      send_word(8'h01, 1'b0, 0, 1'b0);
      send_word(8'h02, 1'b0, 0, 1'b0);
      send_word(8'h03, 1'b0, 0, 1'b0);
      send_word(8'h04, 1'b1, 0, 1'b0);

      // Link clock stuck high
      in_clk = 1'b1;
      repeat (40) @(negedge clk);
      check("lost_early", {31'd0, clk_lost}, 32'd0);
      check("locked_early", {31'd0, locked}, 32'd1);
      repeat (35) @(negedge clk);
      check("lost_late", {31'd0, clk_lost}, 32'd1);
      check("locked_late", {31'd0, locked}, 32'd0);

      // Resume and relock, then cross the 0xFF -> 0x00 wrap
      send_word(8'hFA, 1'b0, 0, 1'b0);
      send_word(8'hFB, 1'b0, 0, 1'b0);
      send_word(8'hFC, 1'b0, 0, 1'b0);
      send_word(8'hFD, 1'b0, 0, 1'b0);
      send_word(8'hFE, 1'b1, 0, 1'b0);
      send_word(8'hFF, 1'b1, 0, 1'b0);
      send_word(8'h00, 1'b1, 0, 1'b0);
      send_word(8'h01, 1'b1, 0, 1'b0);

      // Single bad word, stream resyncs to 0x56
      send_word(8'h02, 1'b1, 0, 1'b0);
      send_word(8'h03, 1'b1, 0, 1'b0);
      send_word(8'h55, 1'b1, 1, 1'b0);
      send_word(8'h56, 1'b1, 1, 1'b0);
      send_word(8'h57, 1'b1, 1, 1'b0);

      // Three consecutive bad words drop lock; no counting while in ACQ
      send_word(8'h58, 1'b1, 1, 1'b0);
      send_word(8'h77, 1'b1, 2, 1'b0);
      send_word(8'h05, 1'b1, 3, 1'b0);
      send_word(8'h99, 1'b1, 4, 1'b0);
      send_word(8'h9A, 1'b0, 4, 1'b0);
      send_word(8'h9B, 1'b0, 4, 1'b0);
      send_word(8'h9C, 1'b0, 4, 1'b0);
      send_word(8'h9D, 1'b1, 4, 1'b0);

      // Bring err_cnt to 5, then clear and mismatch on the same cycle
      send_word(8'h00, 1'b1, 5, 1'b0);
      send_word(8'h01, 1'b1, 5, 1'b0);
      send_word(8'h40, 1'b1, 1, 1'b1);

      // Reset in the middle of a word
      @(negedge clk);
      err_clr = 1'b0;
      in_clk  = 1'b1;
      din     = 8'h41;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_dout", {24'd0, dout}, 32'd0);
      check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
      check("mid_rst_locked", {31'd0, locked}, 32'd0);
      check("mid_rst_clk_lost", {31'd0, clk_lost}, 32'd1);
      check("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      in_clk = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // First word after reset is hunted afresh
      send_word(8'h30, 1'b0, 0, 1'b0);
      send_word(8'h31, 1'b0, 0, 1'b0);
      send_word(8'h32, 1'b0, 0, 1'b0);
      send_word(8'h33, 1'b0, 0, 1'b0);
      send_word(8'h34, 1'b1, 0, 1'b0);

      repeat (8) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/slon_rx.md
Name: slon_rx

Overview:
- Receive end of the slon source-synchronous link.
- Link carries a divided clock `in_clk` and a `DOUT_WIDTH`-bit data word. Data changes on the rising edge of `in_clk` and is stable across its falling edge.
- Block oversamples both inputs in its own clock domain and captures one word per `in_clk` falling edge.
- It checks that the word stream is incrementing (mod 2^`DOUT_WIDTH`), reports lock and error count, and detects loss of `in_clk`.

Parameters:
- `DOUT_WIDTH`, 8: link data width.
- `SYNC_STAGES`, 2: synchronizer depth on `in_clk` and `din` (≥ 2).
- `LOCK_COUNT`, 4: consecutive good words needed to declare lock (≥ 1).
- `UNLOCK_COUNT`, 3: consecutive bad words in LOCKED that drop to ACQ (≥ 1).
- `TIMEOUT`, 64: `clk` cycles without an `in_clk` falling edge before link is declared lost.
- `ERR_CNT_WIDTH`, 16: error counter width.

Ports:
- `clk` in 1: system clock; must be ≥ 4× `in_clk` frequency.
- `rst` in 1: synchronous reset, active-high.
- `in_clk` in 1: link clock, asynchronous to `clk`.
- `din` in `DOUT_WIDTH`: link data, asynchronous to `clk`.
- `err_clr` in 1: single-cycle pulse; clears `err_cnt`.
- `dout` out `DOUT_WIDTH`: last captured word.
- `dout_valid` out 1: one-cycle strobe when `dout` updates.
- `locked` out 1: FSM is in LOCKED.
- `clk_lost` out 1: no `in_clk` edge for `TIMEOUT` cycles.
- `err_cnt` out `ERR_CNT_WIDTH`: saturating mismatch count while LOCKED.

Behaviour:
- **Interface:** one clock `clk`; reset `rst` is synchronous and active-high. All registers update on `posedge clk` only.
- **Reset values:** `dout` = 0, `dout_valid` = 0, `locked` = 0, `clk_lost` = 1, `err_cnt` = 0. Internally: FSM = HUNT, `match_cnt` = 0, `bad_cnt` = 0, `expected` = 0, timeout counter = 0, edge-detect history = 0.
- **Synchronizer:**
  - `in_clk` and every `din` bit pass through `SYNC_STAGES` flops in parallel, so data and clock have equal delay.
  - One extra history flop on synced `in_clk` provides edge detection.
- **Capture:**
  - Let cycle N be the first `clk` edge that samples `in_clk` = 0 after it was 1.
  - `dout` takes the `din` value sampled at cycle N, and `dout_valid` = 1, during cycle N+`SYNC_STAGES`+1 only.
  - Latency is fixed at `SYNC_STAGES`+1.
- **Timeout:**
  - Counter increments every cycle and resets to 0 on each detected falling edge.
  - On reaching `TIMEOUT`-1: `clk_lost` <= 1, FSM <= HUNT, `locked` <= 0; counter holds (no wrap).
  - The next detected edge clears `clk_lost` in the same cycle that `dout_valid` asserts.
- **FSM** (evaluated only on a capture cycle, except the timeout rule):
  - HUNT: `expected` <= word+1, `match_cnt` <= 1. If `LOCK_COUNT` == 1, go to LOCKED; otherwise go to ACQ.
  - ACQ, word == `expected`: `match_cnt`++, `expected` <= word+1. When `match_cnt`+1 == `LOCK_COUNT`, go to LOCKED and set `bad_cnt` <= 0.
  - ACQ, mismatch: `match_cnt` <= 1, `expected` <= word+1, stay in ACQ.
  - LOCKED, match: `bad_cnt` <= 0, `expected` <= word+1.
  - LOCKED, mismatch: `err_cnt`++ (saturates at all-ones), `bad_cnt`++, `expected` <= word+1 (resync to stream). When `bad_cnt`+1 == `UNLOCK_COUNT`, go to ACQ with `match_cnt` <= 1.
- **Outputs:** `locked` is a registered decode of the state (asserts the cycle after the transition).
- **Wrap-around:** `expected` arithmetic is mod 2^`DOUT_WIDTH`, so 0xFF → 0x00 is a match.
- **Simultaneous events:**
  - `err_clr` with a mismatch in the same cycle: `err_cnt` <= 1 (clear, then count).
  - Timeout and capture in the same cycle cannot occur, because a capture resets the counter.
- **Reset mid-word:** all state returns to reset values; the first edge after reset is treated as HUNT.

Decomposition:
- `slon_pkg` holds:
  - the `DOUT_WIDTH` default, shared with the transmitter;
  - the state enum `RxState_t` {HUNT, ACQ, LOCKED};
  - `Data_t` typedef.
- One sub-module, `slon_sync`: parameterized-width, `SYNC_STAGES`-deep flop chain with `ASYNC_REG` attribute. Instantiated once over the concatenation {`in_clk`, `din`}.

Test Plan:
- Reset, then the transmitter pattern (`in_clk` period 8 `clk`, `din` 0x00,0x01,…) → `dout_valid` exactly every 8 cycles; first `dout` = 0x00 at cycle N+3; `locked` = 1 after the 4th word; `err_cnt` = 0.
- Locked stream 0xFD→0xFE→0xFF→0x00→0x01 → no error; `locked` stays 1 across the wrap.
- Inject a single bad word (0x10,0x11,0x55,0x56,0x57) → `err_cnt` = 1; `locked` stays 1; stream resyncs to 0x56.
- Three consecutive bad words while locked (0x20,0x77,0x05,0x99) → `err_cnt` = 3, `locked` drops; 4 good words relock it.
- Hold `in_clk` high for 64 cycles → `clk_lost` = 1, `locked` = 0; resume → `clk_lost` clears on the first `dout_valid`; relock after 4 words.
- Assert `err_clr` on the same cycle as a mismatch capture with `err_cnt` = 5 → `err_cnt` = 1. Then assert `rst` mid-stream → all outputs return to reset values on the next cycle.
